// File: rtl/pcileech_ft601_pkg.sv
// Shared types and constants for the FT601 chip-side responder.
package pcileech_ft601_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_ERR
    } bus_state_t;

    localparam logic [3:0] FT601_BE_FULL = 4'hF;
    localparam int         CNT_W         = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pcileech_ft601_resp_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; callers never pop empty
// and only push at full when popping in the same cycle.
module pcileech_ft601_resp_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wptr;
    logic [DEPTH_LOG2:0] rptr;

    always_ff @(posedge clk) begin
        if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wptr[DEPTH_LOG2-1:0]] <= push_data;
    end

    // Extra pointer bit separates full from empty when the index bits match.
    assign head  = mem[rptr[DEPTH_LOG2-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                   (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
    assign count = wptr - rptr;

endmodule

// File: rtl/pcileech_ft601_responder.sv
// FT601 245-mode chip model: injected words are served on the read protocol,
// FPGA writes are captured and handed out on a stream port.
module pcileech_ft601_responder
    import pcileech_ft601_pkg::*;
#(
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int TX_DEPTH_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inj_data,
    input  logic              inj_valid,
    output logic              inj_ready,
    output logic [31:0]       cap_data,
    output logic [3:0]        cap_be,
    output logic              cap_valid,
    input  logic              cap_ready,
    input  logic [31:0]       ft601_data_in,
    input  logic [3:0]        ft601_be_in,
    output logic [31:0]       ft601_data_out,
    output logic [3:0]        ft601_be_out,
    output logic              ft601_data_oe,
    output logic              ft601_rxf_n,
    output logic              ft601_txe_n,
    input  logic              ft601_rd_n,
    input  logic              ft601_oe_n,
    input  logic              ft601_wr_n,
    input  logic              ft601_rst_n,
    output logic              err_conflict,
    output logic [CNT_W-1:0]  drop_count,
    output logic [CNT_W-1:0]  underrun_count
);

    logic flush;
    assign flush = rst | ~ft601_rst_n;

    bus_state_t state, state_nxt;

    logic [31:0]              rx_head;
    logic                     rx_empty, rx_full, rx_push, rx_pop;
    logic [RX_DEPTH_LOG2:0]   rx_count;
    logic [35:0]              tx_head;
    logic                     tx_empty, tx_full, tx_push, tx_pop;
    logic [TX_DEPTH_LOG2:0]   tx_count;

    logic wr_try, underrun, drop;

    always_ff @(posedge clk) begin
        if (flush) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!ft601_oe_n && !ft601_wr_n) begin
            state_nxt = ST_ERR;
        end else begin
            case (state)
                ST_IDLE: if (!ft601_oe_n)     state_nxt = ST_RD;
                         else if (!ft601_wr_n) state_nxt = ST_WR;
                ST_RD:   if (ft601_oe_n)       state_nxt = ST_IDLE;
                ST_WR:   if (ft601_wr_n)       state_nxt = ST_IDLE;
                default: if (ft601_oe_n && ft601_wr_n) state_nxt = ST_IDLE;
            endcase
        end
    end

    assign inj_ready = ~rx_full;
    assign rx_push   = inj_valid & ~rx_full;
    assign rx_pop    = (state == ST_RD) & ~ft601_rd_n & ~ft601_oe_n & ~rx_empty;
    assign underrun  = (state != ST_ERR) & ~ft601_rd_n & ~ft601_oe_n & rx_empty;

    assign cap_valid = ~tx_empty;
    assign tx_pop    = ~tx_empty & cap_ready;
    // A write at full still lands if the capture side frees a slot this cycle.
    assign wr_try    = (state != ST_ERR) & ~ft601_wr_n & ft601_oe_n;
    assign tx_push   = wr_try & (~tx_full | tx_pop);
    assign drop      = wr_try & tx_full & ~tx_pop;

    pcileech_ft601_resp_fifo #(.WIDTH(32), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx (
        .clk       (clk),
        .clr       (flush),
        .push      (rx_push),
        .push_data (inj_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full),
        .count     (rx_count)
    );

    pcileech_ft601_resp_fifo #(.WIDTH(36), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx (
        .clk       (clk),
        .clr       (flush),
        .push      (tx_push),
        .push_data ({ft601_data_in, ft601_be_in}),
        .pop       (tx_pop),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full),
        .count     (tx_count)
    );

    assign cap_data = tx_head[35:4];
    assign cap_be   = tx_head[3:0];

    assign ft601_rxf_n    = (rx_count == '0);
    assign ft601_txe_n    = (tx_count == (TX_DEPTH_LOG2+1)'(1 << TX_DEPTH_LOG2));
    assign ft601_data_out = rx_empty ? 32'h0 : rx_head;
    assign ft601_be_out   = ft601_data_oe ? FT601_BE_FULL : 4'h0;

    // Output enable lags oe_n by one cycle to give the bus a turnaround slot.
    always_ff @(posedge clk) begin
        if (flush) begin
            ft601_data_oe  <= 1'b0;
            err_conflict   <= 1'b0;
            drop_count     <= '0;
            underrun_count <= '0;
        end else begin
            ft601_data_oe <= ~ft601_oe_n & ft601_wr_n;
            if (state_nxt == ST_ERR) err_conflict <= 1'b1;
            if (underrun) underrun_count <= sat_inc(underrun_count);
            if (drop)     drop_count     <= sat_inc(drop_count);
        end
    end

endmodule

// File: tb/tb_pcileech_ft601_responder.sv
// Directed and randomized bench for the FT601 responder against a queue-based model.
module tb_pcileech_ft601_responder;

    localparam int RXL = 4;
    localparam int TXL = 2;
    localparam int RXD = 1 << RXL;
    localparam int TXD = 1 << TXL;
    localparam int M_IDLE = 0, M_RD = 1, M_WR = 2, M_ERR = 3;

    logic        clk = 1'b0;
    logic        rst, inj_valid, inj_ready, cap_valid, cap_ready;
    logic [31:0] inj_data, cap_data, ft601_data_in, ft601_data_out;
    logic [3:0]  cap_be, ft601_be_in, ft601_be_out;
    logic        ft601_data_oe, ft601_rxf_n, ft601_txe_n;
    logic        ft601_rd_n, ft601_oe_n, ft601_wr_n, ft601_rst_n, err_conflict;
    logic [15:0] drop_count, underrun_count;

    always #5 clk = ~clk;

    pcileech_ft601_responder #(.RX_DEPTH_LOG2(RXL), .TX_DEPTH_LOG2(TXL)) dut (
        .clk(clk), .rst(rst),
        .inj_data(inj_data), .inj_valid(inj_valid), .inj_ready(inj_ready),
        .cap_data(cap_data), .cap_be(cap_be), .cap_valid(cap_valid), .cap_ready(cap_ready),
        .ft601_data_in(ft601_data_in), .ft601_be_in(ft601_be_in),
        .ft601_data_out(ft601_data_out), .ft601_be_out(ft601_be_out),
        .ft601_data_oe(ft601_data_oe), .ft601_rxf_n(ft601_rxf_n), .ft601_txe_n(ft601_txe_n),
        .ft601_rd_n(ft601_rd_n), .ft601_oe_n(ft601_oe_n), .ft601_wr_n(ft601_wr_n),
        .ft601_rst_n(ft601_rst_n), .err_conflict(err_conflict),
        .drop_count(drop_count), .underrun_count(underrun_count)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: queues for the two buffers, bus phase, sticky flags.
    logic [31:0] m_rx[$];
    logic [35:0] m_tx[$];
    int          m_st = M_IDLE;
    bit          m_oe = 0, m_err = 0;
    int          m_drop = 0, m_under = 0;

    task automatic model_check();
        logic [35:0] t;
        logic [31:0] r;
        chk("rxf_n", ft601_rxf_n, m_rx.size() == 0);
        chk("txe_n", ft601_txe_n, m_tx.size() == TXD);
        chk("inj_ready", inj_ready, m_rx.size() < RXD);
        chk("cap_valid", cap_valid, m_tx.size() != 0);
        if (m_tx.size() != 0) begin
            t = m_tx[0];
            chk("cap_data", cap_data, t[35:4]);
            chk("cap_be", cap_be, t[3:0]);
        end
        r = (m_rx.size() != 0) ? m_rx[0] : 32'h0;
        chk("data_out", ft601_data_out, r);
        chk("data_oe", ft601_data_oe, m_oe);
        chk("be_out", ft601_be_out, m_oe ? 4'hF : 4'h0);
        chk("err_conflict", err_conflict, m_err);
        chk("drop_count", drop_count, m_drop);
        chk("underrun_count", underrun_count, m_under);
    endtask

    task automatic model_step();
        bit cpop, inj, rpop, under, wtry, wpush;
        int ns;
        if (rst || !ft601_rst_n) begin
            m_rx.delete(); m_tx.delete();
            m_st = M_IDLE; m_oe = 0; m_err = 0; m_drop = 0; m_under = 0;
            return;
        end
        cpop  = (m_tx.size() != 0) && cap_ready;
        inj   = inj_valid && (m_rx.size() < RXD);
        rpop  = (m_st == M_RD) && !ft601_rd_n && !ft601_oe_n && (m_rx.size() != 0);
        under = (m_st != M_ERR) && !ft601_rd_n && !ft601_oe_n && (m_rx.size() == 0);
        wtry  = (m_st != M_ERR) && !ft601_wr_n && ft601_oe_n;
        wpush = wtry && ((m_tx.size() < TXD) || cpop);
        if (rpop) void'(m_rx.pop_front());
        if (inj)  m_rx.push_back(inj_data);
        if (cpop) void'(m_tx.pop_front());
        if (wpush) m_tx.push_back({ft601_data_in, ft601_be_in});
        if (wtry && !wpush && m_drop < 65535) m_drop++;
        if (under && m_under < 65535) m_under++;
        m_oe = !ft601_oe_n && ft601_wr_n;
        if (!ft601_oe_n && !ft601_wr_n) ns = M_ERR;
        else if (m_st == M_IDLE) ns = !ft601_oe_n ? M_RD : (!ft601_wr_n ? M_WR : M_IDLE);
        else if (m_st == M_RD)   ns = ft601_oe_n ? M_IDLE : M_RD;
        else if (m_st == M_WR)   ns = ft601_wr_n ? M_IDLE : M_WR;
        else                     ns = (ft601_oe_n && ft601_wr_n) ? M_IDLE : M_ERR;
        if (ns == M_ERR) m_err = 1;
        m_st = ns;
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; ft601_rst_n = 1; inj_valid = 0; inj_data = '0; cap_ready = 0;
        ft601_data_in = '0; ft601_be_in = '0; ft601_rd_n = 1; ft601_oe_n = 1; ft601_wr_n = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("rst_rxf_n", ft601_rxf_n, 1);
        chk("rst_txe_n", ft601_txe_n, 0);
        chk("rst_data_oe", ft601_data_oe, 0);
        chk("rst_cap_valid", cap_valid, 0);
        chk("rst_err", err_conflict, 0);
        chk("rst_counts", {drop_count, underrun_count}, 0);

        // Read: four injected words served after one turnaround cycle
        for (int i = 0; i < 4; i++) begin
            inj_valid = 1; inj_data = 32'((i + 1) * 32'h11111111);
            tick();
        end
        inj_valid = 0;
        ft601_oe_n = 0;
        #1 chk("rd_t0_oe", ft601_data_oe, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            ft601_rd_n = 0;
            #1;
            chk("rd_oe", ft601_data_oe, 1);
            chk("rd_data", ft601_data_out, 32'((i + 1) * 32'h11111111));
            tick();
        end
        ft601_rd_n = 1; ft601_oe_n = 1;
        #1 chk("rd_rxf_after", ft601_rxf_n, 1);
        tick();

        // Write: three words captured in order
        cap_ready = 1;
        #1 chk("wr_txe", ft601_txe_n, 0);
        for (int i = 0; i < 3; i++) begin
            ft601_wr_n = 0; ft601_data_in = 32'hA0 + i; ft601_be_in = 4'hF;
            #1;
            if (i > 0) chk("wr_cap_data", cap_data, 32'hA0 + i - 1);
            tick();
        end
        ft601_wr_n = 1;
        #1;
        chk("wr_cap_last", cap_data, 32'hA2);
        chk("wr_cap_be", cap_be, 4'hF);
        tick();
        #1 chk("wr_drop", drop_count, 0);

        // Full: six writes into a four-deep buffer, two dropped
        cap_ready = 0;
        for (int i = 0; i < 6; i++) begin
            ft601_wr_n = 0; ft601_data_in = 32'hB0 + i; ft601_be_in = 4'(i);
            #1 chk("full_txe", ft601_txe_n, i >= 4);
            tick();
        end
        ft601_wr_n = 1;
        #1 chk("full_drop", drop_count, 2);
        cap_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("full_order", cap_data, 32'hB0 + i);
            tick();
        end
        #1 chk("full_drained", cap_valid, 0);

        // Underrun: reads against an empty buffer
        for (int i = 0; i < 3; i++) begin
            ft601_oe_n = 0; ft601_rd_n = 0;
            #1 chk("ur_rxf", ft601_rxf_n, 1);
            tick();
        end
        ft601_oe_n = 1; ft601_rd_n = 1;
        #1 chk("ur_count", underrun_count, 3);
        tick();

        // Conflict: one cycle with oe_n and wr_n both low, then a clean write
        cap_ready = 0;
        ft601_oe_n = 0; ft601_wr_n = 0; ft601_data_in = 32'hDEAD; ft601_be_in = 4'h3;
        tick();
        ft601_oe_n = 1; ft601_wr_n = 1;
        #1;
        chk("cf_err", err_conflict, 1);
        chk("cf_no_push", cap_valid, 0);
        tick();
        ft601_wr_n = 0; ft601_data_in = 32'hBEEF; ft601_be_in = 4'hF;
        tick();
        ft601_wr_n = 1;
        #1;
        chk("cf_cap_valid", cap_valid, 1);
        chk("cf_cap_data", cap_data, 32'hBEEF);
        chk("cf_sticky", err_conflict, 1);
        cap_ready = 1;
        tick();

        // Mid-read chip reset with three words queued
        cap_ready = 0;
        for (int i = 0; i < 3; i++) begin
            inj_valid = 1; inj_data = 32'hC0 + i;
            tick();
        end
        inj_valid = 0;
        ft601_oe_n = 0;
        tick();
        ft601_rst_n = 0;
        tick();
        ft601_rst_n = 1; ft601_oe_n = 1;
        #1;
        chk("mr_rxf", ft601_rxf_n, 1);
        chk("mr_data_oe", ft601_data_oe, 0);
        chk("mr_counts", {drop_count, underrun_count}, 0);
        chk("mr_err", err_conflict, 0);
        tick();

        // Randomized traffic, every cycle compared with the model
        for (int i = 0; i < 1500; i++) begin
            rst           = ($urandom_range(0, 299) == 0);
            ft601_rst_n   = ($urandom_range(0, 299) != 0);
            inj_valid     = ($urandom_range(0, 1) == 0);
            inj_data      = $urandom;
            cap_ready     = ($urandom_range(0, 9) < 6);
            ft601_oe_n    = ($urandom_range(0, 9) >= 4);
            ft601_wr_n    = ($urandom_range(0, 9) >= 3);
            ft601_rd_n    = ($urandom_range(0, 1) == 0);
            ft601_data_in = $urandom;
            ft601_be_in   = 4'($urandom);
            tick();
        end
        rst = 0; ft601_rst_n = 1; inj_valid = 0; cap_ready = 0;
        ft601_oe_n = 1; ft601_wr_n = 1; ft601_rd_n = 1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
